// File: rtl/arp_pkg.sv
// Shared ARP frame constants, word indices, FSM state and field payload for the RX and TX paths.
package arp_pkg;

    localparam logic [15:0] MAC_TYPE_ARP    = 16'h0806;
    localparam logic [15:0] HARDWARE_TYPE   = 16'h0001;
    localparam logic [15:0] PROTOCOL_TYPE   = 16'h0800;
    localparam logic [7:0]  HARDWARE_LEN    = 8'd6;
    localparam logic [7:0]  PROTOCOL_LEN    = 8'd4;
    localparam logic [15:0] OPERATION_REQ   = 16'h0001;
    localparam logic [15:0] OPERATION_REPLY = 16'h0002;

    // Word indices within the frame, SOP word is index 0
    localparam int unsigned W_ETYPE  = 3;
    localparam int unsigned W_PTYPE  = 4;
    localparam int unsigned W_OPER   = 5;
    localparam int unsigned W_SHA_LO = 6;
    localparam int unsigned W_SPA    = 7;
    localparam int unsigned W_TPA_HI = 9;
    localparam int unsigned W_TPA_LO = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_DROP,
        ST_DISCARD,
        ST_COMMIT
    } arp_rx_state_t;

    typedef struct packed {
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [31:0] tpa;
    } arp_fields_t;

    function automatic logic is_arp_oper(input logic [15:0] oper);
        return (oper == OPERATION_REQ) || (oper == OPERATION_REPLY);
    endfunction

endpackage

// File: rtl/arp_rx_csr.sv
// ARP receiver register file: control bits, latched frame fields, counters, read mux and interrupt.
module arp_rx_csr
    import arp_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_write,
    input  logic [2:0]  i_address,
    input  logic [3:0]  i_byteenable,
    input  logic [31:0] i_writedata,
    output logic [31:0] o_readdata,
    output logic        o_irq,
    input  logic        i_commit,
    input  arp_fields_t i_fields,
    input  logic        i_bad_inc,
    output logic        o_en,
    output logic        o_filter,
    output logic [31:0] o_local_ip
);

    logic        r_en;
    logic        r_filter;
    logic        r_irq_en;
    logic        r_rx_valid;
    logic        r_irq;
    logic [31:0] r_local_ip;
    logic [15:0] r_good_cnt;
    logic [15:0] r_bad_cnt;
    arp_fields_t r_lat;

    logic        w_wr_ctrl;
    logic        w_wr_cnt;
    logic        w_rx_valid_nxt;
    logic        w_irq_en_nxt;

    assign w_wr_ctrl = i_write && (i_address == 3'd0);
    assign w_wr_cnt  = i_write && (i_address == 3'd5);

    // A commit in the same cycle as W1C leaves rx_valid set
    always_comb begin
        w_rx_valid_nxt = r_rx_valid;
        w_irq_en_nxt   = r_irq_en;
        if (w_wr_ctrl && i_byteenable[0]) begin
            w_irq_en_nxt = i_writedata[2];
        end
        if (w_wr_ctrl && i_byteenable[1] && i_writedata[8]) begin
            w_rx_valid_nxt = 1'b0;
        end
        if (i_commit) begin
            w_rx_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_en       <= 1'b0;
            r_filter   <= 1'b0;
            r_irq_en   <= 1'b0;
            r_rx_valid <= 1'b0;
            r_irq      <= 1'b0;
            r_local_ip <= 32'h0;
            r_good_cnt <= 16'h0;
            r_bad_cnt  <= 16'h0;
            r_lat      <= '0;
        end else begin
            r_irq_en   <= w_irq_en_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_irq      <= w_rx_valid_nxt && w_irq_en_nxt;
            if (w_wr_ctrl && i_byteenable[0]) begin
                r_en     <= i_writedata[0];
                r_filter <= i_writedata[1];
            end
            if (i_write && (i_address == 3'd1)) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_byteenable[b]) begin
                        r_local_ip[8*b +: 8] <= i_writedata[8*b +: 8];
                    end
                end
            end
            if (i_commit) begin
                r_lat <= i_fields;
            end
            // Clear beats a same-cycle increment
            if (w_wr_cnt) begin
                r_good_cnt <= 16'h0;
                r_bad_cnt  <= 16'h0;
            end else begin
                if (i_commit) begin
                    r_good_cnt <= r_good_cnt + 16'd1;
                end
                if (i_bad_inc) begin
                    r_bad_cnt <= r_bad_cnt + 16'd1;
                end
            end
        end
    end

    always_comb begin
        o_readdata = 32'h0;
        case (i_address)
            3'd0:    o_readdata = {r_lat.oper, 7'h0, r_rx_valid, 5'h0, r_irq_en, r_filter, r_en};
            3'd1:    o_readdata = r_local_ip;
            3'd2:    o_readdata = r_lat.sha[47:16];
            3'd3:    o_readdata = {16'h0, r_lat.sha[15:0]};
            3'd4:    o_readdata = r_lat.spa;
            3'd5:    o_readdata = {r_bad_cnt, r_good_cnt};
            3'd6:    o_readdata = r_lat.tpa;
            default: o_readdata = 32'h0;
        endcase
    end

    assign o_irq      = r_irq;
    assign o_en       = r_en;
    assign o_filter   = r_filter;
    assign o_local_ip = r_local_ip;

endmodule

// File: rtl/arp_receiver.sv
// Avalon-ST ARP frame parser: validates header, filters on target IP and hands fields to the CSR block.
module arp_receiver
    import arp_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 16
) (
    input  logic        csi_clock_clk,
    input  logic        csi_clock_reset,
    input  logic [31:0] asi_snk0_data,
    input  logic        asi_snk0_valid,
    input  logic        asi_snk0_startofpacket,
    input  logic        asi_snk0_endofpacket,
    input  logic [1:0]  asi_snk0_empty,
    output logic        asi_snk0_ready,
    input  logic        avs_s0_write,
    input  logic        avs_s0_read,
    input  logic [2:0]  avs_s0_address,
    input  logic [3:0]  avs_s0_byteenable,
    input  logic [31:0] avs_s0_writedata,
    output logic [31:0] avs_s0_readdata,
    output logic        ins_irq0_irq
);

    localparam int unsigned KW = $clog2(MAX_WORDS);

    arp_rx_state_t r_state;
    logic [KW-1:0] r_k;
    logic          r_ready;
    logic          r_commit;
    logic          r_bad_inc;
    arp_fields_t   r_cap;

    logic          w_en;
    logic          w_filter;
    logic [31:0]   w_local_ip;
    logic          w_acc;
    logic          w_sop;
    logic          w_eop;
    logic          w_fail;
    arp_fields_t   w_cap;
    logic          w_unused;

    assign w_acc    = asi_snk0_valid && r_ready;
    assign w_sop    = asi_snk0_startofpacket;
    assign w_eop    = asi_snk0_endofpacket;
    assign w_unused = ^{asi_snk0_empty, avs_s0_read};

    // Header checks and field capture for the word at index r_k
    always_comb begin
        w_fail = 1'b0;
        w_cap  = r_cap;
        if (r_k == KW'(W_ETYPE) && asi_snk0_data != {MAC_TYPE_ARP, HARDWARE_TYPE}) begin
            w_fail = 1'b1;
        end
        if (r_k == KW'(W_PTYPE) && asi_snk0_data != {PROTOCOL_TYPE, HARDWARE_LEN, PROTOCOL_LEN}) begin
            w_fail = 1'b1;
        end
        if (r_k == KW'(W_OPER)) begin
            w_fail         = !is_arp_oper(asi_snk0_data[31:16]);
            w_cap.oper     = asi_snk0_data[31:16];
            w_cap.sha[47:32] = asi_snk0_data[15:0];
        end
        if (r_k == KW'(W_SHA_LO)) begin
            w_cap.sha[31:0] = asi_snk0_data;
        end
        if (r_k == KW'(W_SPA)) begin
            w_cap.spa = asi_snk0_data;
        end
        if (r_k == KW'(W_TPA_HI)) begin
            w_cap.tpa[31:16] = asi_snk0_data[15:0];
        end
        if (r_k == KW'(W_TPA_LO)) begin
            w_cap.tpa[15:0] = asi_snk0_data[31:16];
        end
    end

    always_ff @(posedge csi_clock_clk or posedge csi_clock_reset) begin
        if (csi_clock_reset) begin
            r_state   <= ST_IDLE;
            r_k       <= '0;
            r_ready   <= 1'b0;
            r_commit  <= 1'b0;
            r_bad_inc <= 1'b0;
            r_cap     <= '0;
        end else begin
            r_ready   <= 1'b1;
            r_commit  <= 1'b0;
            r_bad_inc <= 1'b0;
            case (r_state)
                ST_IDLE, ST_COMMIT: begin
                    r_state <= ST_IDLE;
                    if (w_acc && w_sop) begin
                        r_state <= w_en ? ST_RECV : ST_DISCARD;
                        r_k     <= KW'(1);
                    end
                end
                ST_RECV: begin
                    if (w_acc) begin
                        if (w_sop) begin
                            r_bad_inc <= 1'b1;
                            r_state   <= w_en ? ST_RECV : ST_DISCARD;
                            r_k       <= KW'(1);
                        end else begin
                            r_cap <= w_cap;
                            if (w_fail) begin
                                r_bad_inc <= 1'b1;
                                r_state   <= w_eop ? ST_IDLE : ST_DROP;
                            end else if (w_eop) begin
                                if (r_k >= KW'(W_TPA_LO) && (!w_filter || w_cap.tpa == w_local_ip)) begin
                                    r_commit <= 1'b1;
                                    r_state  <= ST_COMMIT;
                                end else begin
                                    r_bad_inc <= 1'b1;
                                    r_state   <= ST_IDLE;
                                end
                            end else if (r_k == KW'(MAX_WORDS - 1)) begin
                                r_bad_inc <= 1'b1;
                                r_state   <= ST_DROP;
                            end else begin
                                r_k <= r_k + KW'(1);
                            end
                        end
                    end
                end
                ST_DROP, ST_DISCARD: begin
                    if (w_acc) begin
                        if (w_sop) begin
                            r_state <= w_en ? ST_RECV : ST_DISCARD;
                            r_k     <= KW'(1);
                        end else if (w_eop) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign asi_snk0_ready = r_ready;

    arp_rx_csr u_csr (
        .i_clk        (csi_clock_clk),
        .i_rst        (csi_clock_reset),
        .i_write      (avs_s0_write),
        .i_address    (avs_s0_address),
        .i_byteenable (avs_s0_byteenable),
        .i_writedata  (avs_s0_writedata),
        .o_readdata   (avs_s0_readdata),
        .o_irq        (ins_irq0_irq),
        .i_commit     (r_commit),
        .i_fields     (r_cap),
        .i_bad_inc    (r_bad_inc),
        .o_en         (w_en),
        .o_filter     (w_filter),
        .o_local_ip   (w_local_ip)
    );

endmodule
